// File: rtl/dmem_bridge_pkg.sv
// Shared CPU defines for the data-memory bridge: FSM encoding, access masks,
// request/bus-command records and the byte-lane mask helper.
package dmem_bridge_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic [3:0] MASK_BYTE   = 4'b0001;
    localparam logic [3:0] MASK_HALF   = 4'b0011;
    localparam logic [3:0] MASK_WORD   = 4'b1111;
    localparam int         TIMEOUT_DEF = 255;

    // Fields of the in-flight access needed again when the data returns.
    typedef struct packed {
        logic [1:0] off;
        logic [3:0] mask;
        logic       sgn;
        logic       we;
    } req_t;

    typedef struct packed {
        logic        req;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
    } bus_cmd_t;

    // Upper nibble non-zero means the access straddles a word boundary.
    function automatic logic [7:0] shift_mask(input logic [3:0] mask, input logic [1:0] off);
        return {4'b0000, mask} << off;
    endfunction

endpackage

// File: rtl/dmem_bridge_if.sv
// Pipeline-side (MEM stage) and bus-side bundles of the data-memory bridge.
// The bridge is the slave of the MEM stage and the master of the memory bus.
interface dmem_mem_if;
    logic        memCe;
    logic        memWr;
    logic        memRr;
    logic [31:0] memAddr;
    logic [31:0] wtData;
    logic [3:0]  w_mask;
    logic [3:0]  r_mask;
    logic        ld_signed;
    logic [31:0] rdData;
    logic        stall;
    logic        mem_err;

    modport master (
        output memCe, memWr, memRr, memAddr, wtData, w_mask, r_mask, ld_signed,
        input  rdData, stall, mem_err
    );
    modport slave (
        input  memCe, memWr, memRr, memAddr, wtData, w_mask, r_mask, ld_signed,
        output rdData, stall, mem_err
    );
endinterface

interface dmem_bus_if;
    logic        bus_req;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [31:0] bus_wdata;
    logic [3:0]  bus_be;
    logic        bus_ack;
    logic [31:0] bus_rdata;

    modport master (
        output bus_req, bus_we, bus_addr, bus_wdata, bus_be,
        input  bus_ack, bus_rdata
    );
    modport slave (
        input  bus_req, bus_we, bus_addr, bus_wdata, bus_be,
        output bus_ack, bus_rdata
    );
endinterface

// File: rtl/dmem_bridge_load_align.sv
// Combinational load extraction: moves the addressed bytes of a bus word down
// to bit 0 and zero- or sign-extends them according to the access size.
module load_align
    import dmem_bridge_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  off,
    input  logic [3:0]  mask,
    input  logic        sgn,
    output logic [31:0] data
);

    logic [31:0] shifted;

    always_comb begin
        shifted = rdata >> {off, 3'b000};
        case (mask)
            MASK_BYTE: data = {{24{sgn & shifted[7]}}, shifted[7:0]};
            MASK_HALF: data = {{16{sgn & shifted[15]}}, shifted[15:0]};
            MASK_WORD: data = shifted;
            default:   data = shifted & {{8{mask[3]}}, {8{mask[2]}}, {8{mask[1]}}, {8{mask[0]}}};
        endcase
    end

endmodule

// File: rtl/dmem_bridge.sv
// Bridges MEM-stage loads/stores onto a req/ack word bus, stalling the pipeline
// until ack, misalignment or timeout; result/error are presented for one cycle.
module dmem_bridge
    import dmem_bridge_pkg::*;
#(
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input  logic       clk,
    input  logic       rst,
    dmem_mem_if.slave  mem,
    dmem_bus_if.master bus
);

    localparam int CW = $clog2(TIMEOUT + 1);

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    req_t          req_q, req_d;
    bus_cmd_t      cmd_q, cmd_d;
    logic [31:0]   rd_data_q, rd_data_d;
    logic          mem_err_q, mem_err_d;

    logic          access;
    logic [3:0]    sel_mask;
    logic [7:0]    sh_mask;
    logic [31:0]   ld_data;

    load_align u_load_align (
        .rdata (bus.bus_rdata),
        .off   (req_q.off),
        .mask  (req_q.mask),
        .sgn   (req_q.sgn),
        .data  (ld_data)
    );

    assign access   = mem.memCe & (mem.memWr | mem.memRr);
    assign sel_mask = mem.memWr ? mem.w_mask : mem.r_mask;
    assign sh_mask  = shift_mask(sel_mask, mem.memAddr[1:0]);

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        req_d     = req_q;
        cmd_d     = cmd_q;
        rd_data_d = '0;
        mem_err_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (access) begin
                    if (sh_mask[7:4] == 4'b0000) begin
                        state_d = ST_BUSY;
                        cnt_d   = '0;
                        req_d   = '{off: mem.memAddr[1:0], mask: sel_mask,
                                    sgn: mem.ld_signed, we: mem.memWr};
                        cmd_d   = '{req: 1'b1, we: mem.memWr,
                                    addr: {mem.memAddr[31:2], 2'b00},
                                    wdata: mem.wtData << {mem.memAddr[1:0], 3'b000},
                                    be: sh_mask[3:0]};
                    end else begin
                        state_d   = ST_DONE;
                        mem_err_d = 1'b1;
                    end
                end
            end
            ST_BUSY: begin
                // Ack is tested first so an ack on the final allowed cycle still succeeds.
                if (bus.bus_ack) begin
                    state_d   = ST_DONE;
                    cnt_d     = '0;
                    cmd_d     = '0;
                    rd_data_d = req_q.we ? 32'h0 : ld_data;
                end else if (cnt_q == CW'(TIMEOUT - 1)) begin
                    state_d   = ST_DONE;
                    cnt_d     = '0;
                    cmd_d     = '0;
                    mem_err_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            req_q     <= '0;
            cmd_q     <= '0;
            rd_data_q <= '0;
            mem_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            req_q     <= req_d;
            cmd_q     <= cmd_d;
            rd_data_q <= rd_data_d;
            mem_err_q <= mem_err_d;
        end
    end

    // The IDLE term makes stall rise in the same cycle the request appears.
    assign mem.stall   = rst & ((state_q == ST_BUSY) | ((state_q == ST_IDLE) & access));
    assign mem.rdData  = rd_data_q;
    assign mem.mem_err = mem_err_q;

    assign bus.bus_req   = cmd_q.req;
    assign bus.bus_we    = cmd_q.we;
    assign bus.bus_addr  = cmd_q.addr;
    assign bus.bus_wdata = cmd_q.wdata;
    assign bus.bus_be    = cmd_q.be;

endmodule

// File: doc/dmem_bridge.md
DMEM_BRIDGE -- requirements
Module: dmem_bridge

Interface
REQ-001 SHALL have parameter TIMEOUT, default 255: maximum BUSY cycles waiting for bus_ack before abort.
REQ-002 SHALL have ports clk  in  1  single clock; all state updates on its rising edge.
REQ-003 SHALL have rst  in  1  reset, synchronous, active-low.
REQ-004 SHALL have memCe  in  1  access request from the MEM stage.
REQ-005 SHALL have memWr / memRr  in  1 each  write / read enables from the MEM stage.
REQ-006 SHALL have memAddr  in  32  byte address.
REQ-007 SHALL have wtData  in  32  store data, low-justified.
REQ-008 SHALL have w_mask / r_mask  in  4 each  low-justified byte masks: 0001 byte, 0011 half, 1111 word.
REQ-009 SHALL have ld_signed  in  1  sign-extend load result.
REQ-010 SHALL have rdData  out  32  load result, right-justified, feeds MEM rdData_i.
REQ-011 SHALL have stall  out  1  freeze the pipeline; MEM inputs are held stable while high.
REQ-012 SHALL have mem_err  out  1  one-cycle pulse on misalignment or timeout.
REQ-013 SHALL have bus_req, bus_we  out  1 each; bus_addr  out  32  word-aligned; bus_wdata  out  32; bus_be  out  4.
REQ-014 SHALL have bus_ack  in  1; bus_rdata  in  32.

Function
REQ-015 SHALL implement FSM states IDLE, BUSY, DONE.
REQ-016 IDLE: when memCe=1 and access is aligned, SHALL latch request fields and go to BUSY; stall=1 that same cycle, combinationally.
REQ-017 Alignment: shifted mask = mask << memAddr[1:0]; if any bit falls beyond bit 3, access SHALL be misaligned: no bus_req, mem_err pulses, go to DONE with rdData=0.
REQ-018 BUSY: bus_req=1, bus_addr={addr[31:2],2'b00}, bus_be=shifted mask, bus_wdata=wtData << 8*addr[1:0], bus_we=memWr; all SHALL hold stable until bus_ack.
REQ-019 BUSY with bus_ack=1: capture bus_rdata, go to DONE; bus_req SHALL drop in the next cycle.
REQ-020 Load extraction: bytes selected by shifted mask SHALL be shifted right by 8*addr[1:0], then zero- or sign-extended from bit 7 (byte) or bit 15 (half) per ld_signed.
REQ-021 Write completion: rdData SHALL be 0 in DONE.
REQ-022 Timeout: counter SHALL count BUSY cycles; on reaching TIMEOUT without ack, drop bus_req, pulse mem_err, go to DONE with rdData=0.
REQ-023 DONE: stall=0, rdData valid for exactly this cycle; SHALL go to IDLE unconditionally. The held request SHALL NOT be reissued.
REQ-024 stall SHALL be 1 in BUSY, and 0 in IDLE when memCe=0.
REQ-025 memCe=1 with both memWr=0 and memRr=0 SHALL be treated as no access (stay IDLE).
REQ-026 bus_ack arriving in IDLE or DONE SHALL be ignored.
REQ-027 bus_ack on the same cycle as the timeout limit SHALL count as success (ack wins).

Reset
REQ-028 rst=0 at a clock edge SHALL force IDLE, timeout counter 0, and outputs rdData=0, bus_req=0, bus_we=0, bus_be=0, bus_addr=0, bus_wdata=0, mem_err=0; stall SHALL be 0.
REQ-029 Reset during BUSY SHALL abandon the transaction with bus_req low the next cycle; no mem_err.

Structure
REQ-030 State encoding, mask constants (BYTE/HALF/WORD) and TIMEOUT default SHALL live in the shared CPU defines package.
REQ-031 Load alignment/extension SHALL be a combinational sub-module, load_align.

Verification
REQ-032 Word load: addr 0x100, r_mask 1111, ack after 3 cycles, bus_rdata 0xDEADBEEF -> stall high for 4 cycles, rdData 0xDEADBEEF in DONE.
REQ-033 Signed byte load: addr 0x103, r_mask 0001, ld_signed=1, bus_rdata 0x80123456 -> bus_be 1000, rdData 0xFFFFFF80.
REQ-034 Half store: addr 0x202, w_mask 0011, wtData 0x0000ABCD -> bus_be 1100, bus_wdata 0xABCD0000, bus_we=1.
REQ-035 Misaligned: addr 0x103, w_mask 0011 -> no bus_req, mem_err pulse, stall 1 cycle.
REQ-036 Timeout: TIMEOUT=4, no ack -> bus_req low after 4 BUSY cycles, mem_err pulse, rdData 0.
REQ-037 Reset mid-BUSY, then a new load -> bus_req low next cycle, no mem_err, next access completes normally.
